// File: rtl/fp_mul_pkg.sv
// Shared types and helpers for the pipelined floating-point multiplier.
// Stage-register structs are sized from EXP_W_P / FRAC_W_P. The fp_mul_pipe
// parameters default to these values, so change widths here.
package fp_mul_pkg;

  localparam int EXP_W_P  = 8;
  localparam int FRAC_W_P = 23;

  typedef enum logic [2:0] {
    RNE = 3'd0,
    RTZ = 3'd1,
    RDN = 3'd2,
    RUP = 3'd3,
    RMM = 3'd4
  } rmode_e;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    SUB  = 3'd1,
    NORM = 3'd2,
    INF  = 3'd3,
    NAN  = 3'd4
  } fclass_e;

  function automatic int bias(input int ew);
    return (1 << (ew - 1)) - 1;
  endfunction

  function automatic int max_exp(input int ew);
    return (1 << ew) - 1;
  endfunction

  // Canonical quiet NaN: sign 0, all-ones exponent, fraction MSB set.
  function automatic logic [63:0] qnan(input int ew, input int fw);
    logic [63:0] v;
    v = ((64'd1 << ew) - 64'd1) << fw;
    v = v | (64'd1 << (fw - 1));
    return v;
  endfunction

  // S1 -> S2: operand classes, sign, biased exponent sum, full mantissa product.
  typedef struct packed {
    logic                        sign;
    fclass_e                     cx;
    fclass_e                     cy;
    logic signed [EXP_W_P+1:0]   esum;
    logic [2*FRAC_W_P+1:0]       prod;
    rmode_e                      mode;
  } s1_t;

  // S2 -> S3: normalised mantissa with hidden bit, guard/round/sticky, exponent.
  typedef struct packed {
    logic                        sign;
    fclass_e                     cx;
    fclass_e                     cy;
    logic signed [EXP_W_P+1:0]   exp;
    logic [FRAC_W_P:0]           frac;
    logic                        g;
    logic                        r;
    logic                        s;
    rmode_e                      mode;
  } s2_t;

endpackage

// File: rtl/fp_mul_round.sv
// Combinational rounding of a normalised mantissa. A carry out of the
// increment renormalises the fraction and bumps the exponent.
module fp_mul_round
  import fp_mul_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                    sign,
  input  logic [FRAC_W:0]         frac,
  input  logic                    g,
  input  logic                    r,
  input  logic                    s,
  input  logic signed [EXP_W+1:0] exp,
  input  rmode_e                  mode,
  output logic [FRAC_W-1:0]       frac_r,
  output logic signed [EXP_W+1:0] exp_r,
  output logic                    carry
);

  logic              up;
  logic [FRAC_W+1:0] sum;

  // Round-up decision per rounding mode; unknown modes round to nearest even.
  always_comb begin
    up = 1'b0;
    case (mode)
      RTZ:     up = 1'b0;
      RDN:     up = sign & (g | r | s);
      RUP:     up = ~sign & (g | r | s);
      RMM:     up = g;
      default: up = g & (r | s | frac[0]);
    endcase
  end

  assign sum    = {1'b0, frac} + {{(FRAC_W+1){1'b0}}, up};
  assign carry  = sum[FRAC_W+1];
  assign frac_r = carry ? sum[FRAC_W:1] : sum[FRAC_W-1:0];
  assign exp_r  = exp + $signed({{(EXP_W+1){1'b0}}, carry});

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage IEEE-754 multiplier: mantissa product, normalise, round/pack.
// Subnormal operands flush to zero; overflow and underflow flags are raised.
// Optional feature: define FP_MUL_INEXACT_EN to add the inexact output nx.
module fp_mul_pipe
  import fp_mul_pkg::*;
#(
  parameter int EXP_W  = EXP_W_P,
  parameter int FRAC_W = FRAC_W_P
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [EXP_W+FRAC_W:0]     fp_X,
  input  logic [EXP_W+FRAC_W:0]     fp_Y,
  input  logic [2:0]                r_mode,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [EXP_W+FRAC_W:0]     fp_Z,
  output logic                      ovrf,
  output logic                      udrf
`ifdef FP_MUL_INEXACT_EN
  ,
  output logic                      nx
`endif
);

  localparam int W   = 1 + EXP_W + FRAC_W;
  localparam int PW  = 2 * FRAC_W + 2;
  localparam int EW2 = EXP_W + 2;
  localparam logic signed [EW2-1:0] BIAS_S = EW2'(bias(EXP_W));
  localparam logic signed [EW2-1:0] MAX_E  = EW2'(max_exp(EXP_W));
  localparam logic signed [EW2-1:0] ZERO_E = '0;
  localparam logic [63:0]           QNAN64 = qnan(EXP_W, FRAC_W);
  localparam logic [W-1:0]          QNAN   = QNAN64[W-1:0];

  function automatic fclass_e classify(input logic [EXP_W-1:0] e, input logic [FRAC_W-1:0] f);
    if (e == '0)      return (f == '0) ? ZERO : SUB;
    else if (e == '1) return (f == '0) ? INF : NAN;
    else              return NORM;
  endfunction

  // Handshake: a stage register loads when it is empty or its contents move
  // on this edge (ready_k = !valid_k || ready_k+1). A beat transfers on any
  // edge where valid && ready are both high; out_ready closes the chain.
  logic v1, v2;
  logic s1_ready, s2_ready, s3_ready;

  assign s3_ready = !out_valid || out_ready;
  assign s2_ready = !v2 || s3_ready;
  assign s1_ready = !v1 || s2_ready;
  assign in_ready = s1_ready;

  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;

  // S1: classify operands, form sign, exponent sum and mantissa product.
  always_comb begin
    s1_d      = '0;
    s1_d.sign = fp_X[W-1] ^ fp_Y[W-1];
    s1_d.cx   = classify(fp_X[W-2:FRAC_W], fp_X[FRAC_W-1:0]);
    s1_d.cy   = classify(fp_Y[W-2:FRAC_W], fp_Y[FRAC_W-1:0]);
    s1_d.esum = EW2'({2'b00, fp_X[W-2:FRAC_W]}) + EW2'({2'b00, fp_Y[W-2:FRAC_W]});
    s1_d.prod = PW'({1'b1, fp_X[FRAC_W-1:0]}) * PW'({1'b1, fp_Y[FRAC_W-1:0]});
    s1_d.mode = (r_mode > 3'd4) ? RNE : rmode_e'(r_mode);
  end

  // S1 register: captures operands' products together with their rounding mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1   <= 1'b0;
      s1_q <= '0;
    end else if (s1_ready) begin
      v1 <= in_valid;
      if (in_valid) s1_q <= s1_d;
    end
  end

  // S2: normalise the product to 1.x and collect guard/round/sticky.
  logic norm_n;
  assign norm_n = s1_q.prod[PW-1];

  always_comb begin
    s2_d      = '0;
    s2_d.sign = s1_q.sign;
    s2_d.cx   = s1_q.cx;
    s2_d.cy   = s1_q.cy;
    s2_d.mode = s1_q.mode;
    if (norm_n) begin
      s2_d.frac = s1_q.prod[PW-1:FRAC_W+1];
      s2_d.g    = s1_q.prod[FRAC_W];
      s2_d.r    = s1_q.prod[FRAC_W-1];
      s2_d.s    = |s1_q.prod[FRAC_W-2:0];
    end else begin
      s2_d.frac = s1_q.prod[PW-2:FRAC_W];
      s2_d.g    = s1_q.prod[FRAC_W-1];
      s2_d.r    = s1_q.prod[FRAC_W-2];
      s2_d.s    = |s1_q.prod[FRAC_W-3:0];
    end
    s2_d.exp = s1_q.esum - BIAS_S + $signed({{(EXP_W+1){1'b0}}, norm_n});
  end

  // S2 register.
  always_ff @(posedge clk) begin
    if (rst) begin
      v2   <= 1'b0;
      s2_q <= '0;
    end else if (s2_ready) begin
      v2 <= v1;
      if (v1) s2_q <= s2_d;
    end
  end

  // S3: round, then apply special-case priority to pick result and flags.
  logic [FRAC_W-1:0]    rnd_frac;
  logic signed [EW2-1:0] rnd_exp;
  logic                 rnd_carry;

  fp_mul_round #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_round (
    .sign   (s2_q.sign),
    .frac   (s2_q.frac),
    .g      (s2_q.g),
    .r      (s2_q.r),
    .s      (s2_q.s),
    .exp    (s2_q.exp),
    .mode   (s2_q.mode),
    .frac_r (rnd_frac),
    .exp_r  (rnd_exp),
    .carry  (rnd_carry)
  );

  logic zx, zy, is_nan, is_inf, is_zero, ovf_c, udf_c;
  assign zx      = (s2_q.cx == ZERO) || (s2_q.cx == SUB);
  assign zy      = (s2_q.cy == ZERO) || (s2_q.cy == SUB);
  assign is_nan  = (s2_q.cx == NAN) || (s2_q.cy == NAN) ||
                   (zx && s2_q.cy == INF) || (zy && s2_q.cx == INF);
  assign is_inf  = (s2_q.cx == INF) || (s2_q.cy == INF);
  assign is_zero = zx || zy;
  // The exponent only moves when rounding carries out.
  assign ovf_c   = rnd_carry ? (rnd_exp >= MAX_E) : (s2_q.exp >= MAX_E);
  assign udf_c   = rnd_exp <= ZERO_E;

  logic [W-1:0] z_d;
  logic         ovf_d, udf_d;
  logic [W-1:0] inf_w, max_w, zero_w;
  assign inf_w  = {s2_q.sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
  assign max_w  = {s2_q.sign, {(EXP_W-1){1'b1}}, 1'b0, {FRAC_W{1'b1}}};
  assign zero_w = {s2_q.sign, {(W-1){1'b0}}};

  // Result selection in special-case priority order.
  always_comb begin
    z_d   = {s2_q.sign, rnd_exp[EXP_W-1:0], rnd_frac};
    ovf_d = 1'b0;
    udf_d = 1'b0;
    if (is_nan) begin
      z_d = QNAN;
    end else if (is_inf) begin
      z_d = inf_w;
    end else if (is_zero) begin
      z_d = zero_w;
    end else if (ovf_c) begin
      ovf_d = 1'b1;
      case (s2_q.mode)
        RTZ:     z_d = max_w;
        RDN:     z_d = s2_q.sign ? inf_w : max_w;
        RUP:     z_d = s2_q.sign ? max_w : inf_w;
        default: z_d = inf_w;
      endcase
    end else if (udf_c) begin
      udf_d = 1'b1;
      z_d   = zero_w;
    end
  end

  // Output register: holds result and flags while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      fp_Z      <= '0;
      ovrf      <= 1'b0;
      udrf      <= 1'b0;
    end else if (s3_ready) begin
      out_valid <= v2;
      if (v2) begin
        fp_Z <= z_d;
        ovrf <= ovf_d;
        udrf <= udf_d;
      end
    end
  end

`ifdef FP_MUL_INEXACT_EN
  logic nx_d;
  // Inexact: lost bits on finite results, always set alongside ovrf/udrf.
  always_comb begin
    nx_d = 1'b0;
    if (!is_nan && !is_inf && !is_zero)
      nx_d = ovf_c || udf_c || s2_q.g || s2_q.r || s2_q.s;
  end

  // nx travels with the output register and holds under stall.
  always_ff @(posedge clk) begin
    if (rst)                 nx <= 1'b0;
    else if (s3_ready && v2) nx <= nx_d;
  end
`endif

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Bench for fp_mul_pipe: directed vector table, scoreboard queue, backpressure,
// random out_ready stream and mid-flight reset.
module tb_fp_mul_pipe;

  localparam int W  = 32;
  localparam int NV = 24;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] fp_X, fp_Y;
  logic [2:0]   r_mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] fp_Z;
  logic         ovrf, udrf;
`ifdef FP_MUL_INEXACT_EN
  logic         nx;
`endif

  // Clock and DUT.
  always #5 clk = ~clk;

  fp_mul_pipe #(.EXP_W(8), .FRAC_W(23)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fp_X      (fp_X),
    .fp_Y      (fp_Y),
    .r_mode    (r_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .fp_Z      (fp_Z),
    .ovrf      (ovrf),
    .udrf      (udrf)
`ifdef FP_MUL_INEXACT_EN
    , .nx      (nx)
`endif
  );

  // Vector table.
  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [2:0]  m;
    logic [31:0] z;
    logic        ov;
    logic        ud;
  } vec_t;

  vec_t vecs [NV];

  task automatic set_vec(input int i, input logic [31:0] x, input logic [31:0] y,
                         input logic [2:0] m, input logic [31:0] z,
                         input logic ov, input logic ud);
    vecs[i].x = x; vecs[i].y = y; vecs[i].m = m;
    vecs[i].z = z; vecs[i].ov = ov; vecs[i].ud = ud;
  endtask

  task automatic load_vectors();
    set_vec( 0, 32'h40400000, 32'h40400000, 3'd1, 32'h41100000, 1'b0, 1'b0);
    set_vec( 1, 32'h3fffffff, 32'h3fffffff, 3'd0, 32'h407ffffe, 1'b0, 1'b0);
    set_vec( 2, 32'h3fffffff, 32'h3fffffff, 3'd3, 32'h407fffff, 1'b0, 1'b0);
    set_vec( 3, 32'h7f000000, 32'h40000000, 3'd0, 32'h7f800000, 1'b1, 1'b0);
    set_vec( 4, 32'h7f000000, 32'h40000000, 3'd1, 32'h7f7fffff, 1'b1, 1'b0);
    set_vec( 5, 32'hff000000, 32'h40000000, 3'd2, 32'hff800000, 1'b1, 1'b0);
    set_vec( 6, 32'h002df854, 32'hc0490fdb, 3'd0, 32'h80000000, 1'b0, 1'b0);
    set_vec( 7, 32'h7f800000, 32'h00000000, 3'd0, 32'h7fc00000, 1'b0, 1'b0);
    set_vec( 8, 32'h00800000, 32'h00800000, 3'd0, 32'h00000000, 1'b0, 1'b1);
    set_vec( 9, 32'h3fc00000, 32'h3f800001, 3'd0, 32'h3fc00002, 1'b0, 1'b0);
    set_vec(10, 32'h3fc00000, 32'h3f800003, 3'd0, 32'h3fc00004, 1'b0, 1'b0);
    set_vec(11, 32'h3fc00000, 32'h3f800003, 3'd4, 32'h3fc00005, 1'b0, 1'b0);
    set_vec(12, 32'h3f800001, 32'h3ffffffe, 3'd0, 32'h40000000, 1'b0, 1'b0);
    set_vec(13, 32'h3f800001, 32'h3ffffffe, 3'd1, 32'h3fffffff, 1'b0, 1'b0);
    set_vec(14, 32'hff000000, 32'h40000000, 3'd3, 32'hff7fffff, 1'b1, 1'b0);
    set_vec(15, 32'h7f000000, 32'h40000000, 3'd2, 32'h7f7fffff, 1'b1, 1'b0);
    set_vec(16, 32'h7f000000, 32'h40000000, 3'd7, 32'h7f800000, 1'b1, 1'b0);
    set_vec(17, 32'hc0000000, 32'h40400000, 3'd0, 32'hc0c00000, 1'b0, 1'b0);
    set_vec(18, 32'h7fc00001, 32'h3f800000, 3'd0, 32'h7fc00000, 1'b0, 1'b0);
    set_vec(19, 32'hff800000, 32'h7f800000, 3'd0, 32'hff800000, 1'b0, 1'b0);
    set_vec(20, 32'h7f800000, 32'h80000000, 3'd0, 32'h7fc00000, 1'b0, 1'b0);
    set_vec(21, 32'h7f000000, 32'h40000000, 3'd3, 32'h7f800000, 1'b1, 1'b0);
    set_vec(22, 32'h3fffffff, 32'h3fffffff, 3'd2, 32'h407ffffe, 1'b0, 1'b0);
    set_vec(23, 32'hbfffffff, 32'h3fffffff, 3'd2, 32'hc07fffff, 1'b0, 1'b0);
  endtask

  // Scoreboard: {ovrf, udrf, fp_Z} expected per accepted operand beat.
  logic [W+1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int n_acc = 0;
  logic done;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_vec++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, expv, $time);
    end
  endtask

  // Output monitor: every valid output cycle is checked against the queue head,
  // so a stalled result that changes is caught; the head pops on handshake.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_out", 64'(out_valid), 64'd0);
      end else begin
        check_eq("result", 64'({ovrf, udrf, fp_Z}), 64'(exp_q[0]));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Driver: present one operand beat, wait (bounded) for acceptance.
  task automatic send(input int i);
    int n;
    fp_X     = vecs[i].x;
    fp_Y     = vecs[i].y;
    r_mode   = vecs[i].m;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check_eq("accept_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
    end else begin
      exp_q.push_back({vecs[i].ov, vecs[i].ud, vecs[i].z});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      n_acc++;
    end
  endtask

  // Latency from the accepting edge (counted as edge 1) to out_valid.
  task automatic check_latency(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq(tag, 64'(n + 1), 64'd3);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    check_eq("drain", 64'(exp_q.size()), 64'd0);
    #1;
  endtask

  // Hard time limit.
  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "time limit");
  end

  // Main sequence.
  initial begin
    load_vectors();
    rst = 1'b1; in_valid = 1'b0; fp_X = '0; fp_Y = '0; r_mode = '0;
    out_ready = 1'b1; done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_fp_z",      64'(fp_Z),      64'd0);
    check_eq("rst_ovrf",      64'(ovrf),      64'd0);
    check_eq("rst_udrf",      64'(udrf),      64'd0);
    check_eq("rst_in_ready",  64'(in_ready),  64'd1);

    // Single op latency, then every table vector back to back.
    send(0);
    check_latency("latency_first");
    wait_idle();
    for (int i = 0; i < NV; i++) send(i);
    wait_idle();

    // Backpressure: out_ready low for 5 cycles while 6 ops stream in.
    n_acc = 0;
    fork
      begin
        send(0); send(1); send(3); send(8); send(12); send(17);
      end
      begin
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_eq("bp_accepts",  64'(n_acc),    64'd3);
        check_eq("bp_in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
      end
    join
    wait_idle();

    // Random vectors with random consumer stalls.
    done = 1'b0;
    fork
      begin
        for (int k = 0; k < 40; k++) send($urandom_range(0, NV - 1));
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    wait_idle();

    // Reset with two ops in flight: they must never appear.
    send(4);
    send(9);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    check_eq("midrst_out_valid", 64'(out_valid), 64'd0);
    check_eq("midrst_fp_z",      64'(fp_Z),      64'd0);
    check_eq("midrst_in_ready",  64'(in_ready),  64'd1);
    rst = 1'b0;
    send(17);
    check_latency("latency_after_rst");
    wait_idle();
    repeat (5) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
